// File: rtl/i2c_target_regfile.sv
// I2C target exposing four 8-bit registers at BASE_ADDR,2'b00..2'b11.
// reg0/reg1 read/write, reg2 read-only status snapshot, reg3 write-only command.
// SCL/SDA are oversampled on clk; SDA is driven open-drain (0 or Z only).
module i2c_target_regfile #(
   parameter logic [4:0] BASE_ADDR = 5'b10100,
   parameter logic [7:0] RESET0    = 8'h00,
   parameter logic [7:0] RESET1    = 8'h3C
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   input  logic [7:0] status_in,
   output logic [7:0] reg0_out,
   output logic [7:0] reg1_out,
   output logic [7:0] cmd_data,
   output logic       cmd_valid,
   output logic       busy
);

   typedef enum logic [2:0] {
      StIdle, StAddr, StAddrAck, StWrData, StWrAck, StRdData, StRdAck, StIgnore
   } state_e;

   logic   scl_s1, scl_s2, scl_p;
   logic   sda_s1, sda_s2, sda_p;
   logic   scl_rise, scl_fall, start_det, stop_det;

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       done_q, done_d;     // byte complete (or read ACK received), act on next fall
   logic [7:0] shift_q, shift_d;
   logic [1:0] sel_q, sel_d;
   logic       rw_q, rw_d;
   logic       oe_q, oe_d;         // 1 = pull SDA low
   logic       busy_q, busy_d;
   logic [7:0] reg0_q, reg0_d;
   logic [7:0] reg1_q, reg1_d;
   logic [7:0] cmd_q, cmd_d;
   logic       cmd_vld_q, cmd_vld_d;
   logic [7:0] rd_src;

   // Two-flop synchronisers plus one history flop for edge detection; idle bus is high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         scl_p  <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
         sda_p  <= 1'b1;
      end else begin
         scl_s1 <= scl;
         scl_s2 <= scl_s1;
         scl_p  <= scl_s2;
         sda_s1 <= sda;
         sda_s2 <= sda_s1;
         sda_p  <= sda_s2;
      end
   end

   assign scl_rise  = scl_s2 & ~scl_p;
   assign scl_fall  = ~scl_s2 & scl_p;
   assign start_det = scl_s2 & sda_p & ~sda_s2;
   assign stop_det  = scl_s2 & ~sda_p & sda_s2;

   // Source of a read byte; status_in is captured only when the shifter loads.
   always_comb begin
      rd_src = 8'h00;
      case (sel_q)
         2'd0: rd_src = reg0_q;
         2'd1: rd_src = reg1_q;
         2'd2: rd_src = status_in;
         2'd3: rd_src = 8'h00;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= 3'd0;
         done_q    <= 1'b0;
         shift_q   <= 8'h00;
         sel_q     <= 2'd0;
         rw_q      <= 1'b0;
         oe_q      <= 1'b0;
         busy_q    <= 1'b0;
         reg0_q    <= RESET0;
         reg1_q    <= RESET1;
         cmd_q     <= 8'h00;
         cmd_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         shift_q   <= shift_d;
         sel_q     <= sel_d;
         rw_q      <= rw_d;
         oe_q      <= oe_d;
         busy_q    <= busy_d;
         reg0_q    <= reg0_d;
         reg1_q    <= reg1_d;
         cmd_q     <= cmd_d;
         cmd_vld_q <= cmd_vld_d;
      end
   end

   // Next-state logic; START/STOP take priority over any SCL edge in the same cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      done_d    = done_q;
      shift_d   = shift_q;
      sel_d     = sel_q;
      rw_d      = rw_q;
      oe_d      = oe_q;
      busy_d    = busy_q;
      reg0_d    = reg0_q;
      reg1_d    = reg1_q;
      cmd_d     = cmd_q;
      cmd_vld_d = 1'b0;

      if (start_det) begin
         state_d = StAddr;
         cnt_d   = 3'd0;
         done_d  = 1'b0;
         oe_d    = 1'b0;
      end else if (stop_det) begin
         state_d = StIdle;
         done_d  = 1'b0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StIgnore: begin
               oe_d = 1'b0;
            end
            StAddr: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s2};
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     // shift_q[6:0] holds address bits 7..1, sda_s2 is R/W
                     if (shift_q[6:2] == BASE_ADDR) begin
                        done_d = 1'b1;
                        sel_d  = shift_q[1:0];
                        rw_d   = sda_s2;
                        busy_d = 1'b1;
                     end else begin
                        state_d = StIgnore;
                     end
                  end
               end else if (scl_fall && done_q) begin
                  done_d  = 1'b0;
                  oe_d    = 1'b1;
                  state_d = StAddrAck;
               end
            end
            StAddrAck: begin
               if (scl_fall) begin
                  cnt_d = 3'd0;
                  if (rw_q) begin
                     shift_d = {rd_src[6:0], 1'b0};
                     oe_d    = ~rd_src[7];
                     state_d = StRdData;
                  end else begin
                     oe_d    = 1'b0;
                     state_d = StWrData;
                  end
               end
            end
            StWrData: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s2};
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) done_d = 1'b1;
               end else if (scl_fall && done_q) begin
                  done_d  = 1'b0;
                  state_d = StWrAck;
                  oe_d    = (sel_q != 2'd2);
                  case (sel_q)
                     2'd0: reg0_d = shift_q;
                     2'd1: reg1_d = shift_q;
                     2'd2: ;
                     2'd3: begin
                        cmd_d     = shift_q;
                        cmd_vld_d = 1'b1;
                     end
                  endcase
               end
            end
            StWrAck: begin
               if (scl_fall) begin
                  oe_d    = 1'b0;
                  cnt_d   = 3'd0;
                  state_d = StWrData;
               end
            end
            StRdData: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) done_d = 1'b1;
               end else if (scl_fall) begin
                  if (done_q) begin
                     done_d  = 1'b0;
                     oe_d    = 1'b0;
                     state_d = StRdAck;
                  end else begin
                     oe_d    = ~shift_q[7];
                     shift_d = {shift_q[6:0], 1'b0};
                  end
               end
            end
            StRdAck: begin
               if (scl_rise) begin
                  if (sda_s2) state_d = StIgnore;
                  else        done_d  = 1'b1;
               end else if (scl_fall && done_q) begin
                  done_d  = 1'b0;
                  cnt_d   = 3'd0;
                  shift_d = {rd_src[6:0], 1'b0};
                  oe_d    = ~rd_src[7];
                  state_d = StRdData;
               end
            end
         endcase
      end
   end

   assign sda       = oe_q ? 1'b0 : 1'bz;
   assign reg0_out  = reg0_q;
   assign reg1_out  = reg1_q;
   assign cmd_data  = cmd_q;
   assign cmd_valid = cmd_vld_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: acts as the I2C controller. Expected values are queued
// before each transaction; observations are queued after it and a monitor pairs them up.
module tb_i2c_target_regfile;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scl = 1'b1;
   logic       m_drv = 1'b0;
   logic [7:0] status_in = 8'h00;
   wire        sda;
   logic [7:0] reg0_out, reg1_out, cmd_data;
   logic       cmd_valid, busy;

   assign sda = m_drv ? 1'b0 : 1'bz;
   pullup (sda);

   always #5 clk = ~clk;

   i2c_target_regfile dut (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda       (sda),
      .status_in (status_in),
      .reg0_out  (reg0_out),
      .reg1_out  (reg1_out),
      .cmd_data  (cmd_data),
      .cmd_valid (cmd_valid),
      .busy      (busy)
   );

   typedef struct {
      string      name;
      logic [7:0] val;
   } item_t;

   item_t exp_q[$];
   item_t obs_q[$];
   int    total = 0;
   int    bad = 0;
   bit    done = 1'b0;

   // Free-running event counters; the stimulus works with deltas.
   int cmd_cycles = 0;
   int busy_cycles = 0;
   int tgt_low_cycles = 0;
   always @(negedge clk) begin
      if (cmd_valid) cmd_cycles++;
      if (busy) busy_cycles++;
      if (!m_drv && sda === 1'b0) tgt_low_cycles++;
   end

   task automatic expect_v(input string n, input logic [7:0] v);
      item_t it;
      it.name = n;
      it.val  = v;
      exp_q.push_back(it);
   endtask

   task automatic observe(input string n, input logic [7:0] v);
      item_t it;
      it.name = n;
      it.val  = v;
      obs_q.push_back(it);
   endtask

   function automatic logic [7:0] sda_lvl();
      return (sda === 1'b0) ? 8'd0 : 8'd1;
   endfunction

   // Monitor: pairs observations with expectations, and owns the summary.
   initial begin
      item_t o, e;
      int    cyc;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL %s: got %h, required nothing queued", o.name, o.val);
            end else begin
               e = exp_q.pop_front();
               if (e.name != o.name || e.val !== o.val) begin
                  bad++;
                  $display("FAIL %s: got %h, required %h (%s)", o.name, o.val, e.val, e.name);
               end
            end
         end
         if (done || cyc > 60000) begin
            if (!done) begin
               bad++;
               $display("FAIL watchdog: got cycle %0d, required finish", cyc);
            end
            if (exp_q.size() != 0) begin
               total += exp_q.size();
               bad   += exp_q.size();
               $display("FAIL leftover: got %0d unobserved, required 0", exp_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
      end
   end

   task automatic tk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bit_w(input logic b);
      m_drv = ~b;
      tk(4);
      scl = 1'b1;
      tk(8);
      scl = 1'b0;
      tk(4);
   endtask

   task automatic bit_r(output logic b);
      m_drv = 1'b0;
      tk(4);
      scl = 1'b1;
      tk(4);
      b = (sda === 1'b0) ? 1'b0 : 1'b1;
      tk(4);
      scl = 1'b0;
      tk(4);
   endtask

   task automatic i2c_start();
      m_drv = 1'b0;
      tk(4);
      scl = 1'b1;
      tk(8);
      m_drv = 1'b1;
      tk(8);
      scl = 1'b0;
      tk(4);
   endtask

   task automatic i2c_stop();
      m_drv = 1'b1;
      tk(4);
      scl = 1'b1;
      tk(8);
      m_drv = 1'b0;
      tk(8);
   endtask

   task automatic byte_w(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) bit_w(d[i]);
      bit_r(ack);
   endtask

   // chg_at: bit index (0 = first bit) at which status_in changes; -1 for never.
   task automatic byte_r(input logic nack, input int chg_at, input logic [7:0] chg_val,
                         output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         if (7 - i == chg_at) status_in = chg_val;
         bit_r(b);
         d[i] = b;
      end
      bit_w(nack);
   endtask

   task automatic pulse_rst();
      rst = 1'b0;
      tk(2);
      rst = 1'b1;
      tk(4);
   endtask

   initial begin
      logic       a;
      logic [7:0] d;
      int         c0, b0, t0;

      // Reset state
      tk(4);
      expect_v("rst_reg0", 8'h00);
      expect_v("rst_reg1", 8'h3C);
      expect_v("rst_cmd", 8'h00);
      expect_v("rst_cmd_valid", 8'h00);
      expect_v("rst_busy", 8'h00);
      expect_v("rst_sda", 8'h01);
      observe("rst_reg0", reg0_out);
      observe("rst_reg1", reg1_out);
      observe("rst_cmd", cmd_data);
      observe("rst_cmd_valid", {7'd0, cmd_valid});
      observe("rst_busy", {7'd0, busy});
      observe("rst_sda", sda_lvl());
      rst = 1'b1;
      tk(4);

      // Write 0x50 <- 0xA5
      expect_v("w50_aack", 8'h00);
      expect_v("w50_dack", 8'h00);
      expect_v("w50_reg0", 8'hA5);
      expect_v("w50_reg1", 8'h3C);
      expect_v("w50_busy_end", 8'h00);
      i2c_start();
      byte_w(8'hA0, a); observe("w50_aack", {7'd0, a});
      byte_w(8'hA5, a); observe("w50_dack", {7'd0, a});
      observe("w50_reg0", reg0_out);
      observe("w50_reg1", reg1_out);
      i2c_stop();
      observe("w50_busy_end", {7'd0, busy});

      // After reset, read 0x51 -> 0x3C, NACK, STOP
      pulse_rst();
      expect_v("r51_aack", 8'h00);
      expect_v("r51_busy", 8'h01);
      expect_v("r51_data", 8'h3C);
      expect_v("r51_busy_end", 8'h00);
      expect_v("r51_sda_end", 8'h01);
      i2c_start();
      byte_w(8'hA3, a); observe("r51_aack", {7'd0, a});
      observe("r51_busy", {7'd0, busy});
      byte_r(1'b1, -1, 8'h00, d); observe("r51_data", d);
      i2c_stop();
      observe("r51_busy_end", {7'd0, busy});
      observe("r51_sda_end", sda_lvl());

      // Read 0x52 status; a mid-byte change of status_in must not show
      status_in = 8'h5A;
      expect_v("r52_aack", 8'h00);
      expect_v("r52_data", 8'h5A);
      i2c_start();
      byte_w(8'hA5, a); observe("r52_aack", {7'd0, a});
      byte_r(1'b1, 3, 8'h11, d); observe("r52_data", d);
      i2c_stop();

      // Write 0x52 <- 0xFF: NACKed data, no state change
      c0 = cmd_cycles;
      expect_v("w52_aack", 8'h00);
      expect_v("w52_dack", 8'h01);
      expect_v("w52_reg0", 8'h00);
      expect_v("w52_reg1", 8'h3C);
      expect_v("w52_cmd_cycles", 8'h00);
      i2c_start();
      byte_w(8'hA4, a); observe("w52_aack", {7'd0, a});
      byte_w(8'hFF, a); observe("w52_dack", {7'd0, a});
      i2c_stop();
      observe("w52_reg0", reg0_out);
      observe("w52_reg1", reg1_out);
      observe("w52_cmd_cycles", 8'(cmd_cycles - c0));

      // Write 0x53 <- 0x7E: one-cycle command pulse; then read 0x53 -> 0x00
      c0 = cmd_cycles;
      expect_v("w53_aack", 8'h00);
      expect_v("w53_dack", 8'h00);
      expect_v("w53_cmd", 8'h7E);
      expect_v("w53_cmd_cycles", 8'h01);
      expect_v("r53_aack", 8'h00);
      expect_v("r53_data", 8'h00);
      i2c_start();
      byte_w(8'hA6, a); observe("w53_aack", {7'd0, a});
      byte_w(8'h7E, a); observe("w53_dack", {7'd0, a});
      i2c_stop();
      observe("w53_cmd", cmd_data);
      observe("w53_cmd_cycles", 8'(cmd_cycles - c0));
      i2c_start();
      byte_w(8'hA7, a); observe("r53_aack", {7'd0, a});
      byte_r(1'b1, -1, 8'h00, d); observe("r53_data", d);
      i2c_stop();

      // Two-byte write to 0x51 keeps the last byte; two-byte read reloads it
      expect_v("w51_aack", 8'h00);
      expect_v("w51_d1ack", 8'h00);
      expect_v("w51_d2ack", 8'h00);
      expect_v("w51_reg1", 8'h22);
      expect_v("r51b_byte1", 8'h22);
      expect_v("r51b_byte2", 8'h22);
      i2c_start();
      byte_w(8'hA2, a); observe("w51_aack", {7'd0, a});
      byte_w(8'h11, a); observe("w51_d1ack", {7'd0, a});
      byte_w(8'h22, a); observe("w51_d2ack", {7'd0, a});
      i2c_stop();
      observe("w51_reg1", reg1_out);
      i2c_start();
      byte_w(8'hA3, a);
      byte_r(1'b0, -1, 8'h00, d); observe("r51b_byte1", d);
      byte_r(1'b1, -1, 8'h00, d); observe("r51b_byte2", d);
      i2c_stop();

      // Foreign address 0x48: no ACK, never busy, SDA never pulled by the target
      b0 = busy_cycles;
      t0 = tgt_low_cycles;
      expect_v("a48_ack", 8'h01);
      expect_v("a48_busy_cycles", 8'h00);
      expect_v("a48_tgt_low", 8'h00);
      expect_v("a48_reg0", 8'h00);
      expect_v("a48_reg1", 8'h22);
      expect_v("a48_cmd", 8'h7E);
      i2c_start();
      byte_w(8'h90, a); observe("a48_ack", {7'd0, a});
      i2c_stop();
      observe("a48_busy_cycles", 8'(busy_cycles - b0));
      observe("a48_tgt_low", 8'(tgt_low_cycles - t0));
      observe("a48_reg0", reg0_out);
      observe("a48_reg1", reg1_out);
      observe("a48_cmd", cmd_data);

      // Reset during the 4th address bit of a write to 0x50 after reg0 was set
      expect_v("pre_rst_reg0", 8'h5C);
      expect_v("mid_rst_reg0", 8'h00);
      expect_v("mid_rst_reg1", 8'h3C);
      expect_v("mid_rst_cmd", 8'h00);
      expect_v("mid_rst_busy", 8'h00);
      i2c_start();
      byte_w(8'hA0, a);
      byte_w(8'h5C, a);
      i2c_stop();
      observe("pre_rst_reg0", reg0_out);
      i2c_start();
      bit_w(1'b1);
      bit_w(1'b0);
      bit_w(1'b1);
      m_drv = 1'b1;
      tk(4);
      scl = 1'b1;
      tk(4);
      rst = 1'b0;
      tk(2);
      observe("mid_rst_reg0", reg0_out);
      observe("mid_rst_reg1", reg1_out);
      observe("mid_rst_cmd", cmd_data);
      observe("mid_rst_busy", {7'd0, busy});
      scl = 1'b0;
      tk(4);
      m_drv = 1'b0;
      tk(4);
      rst = 1'b1;
      tk(4);

      // Reset while the target is driving the address ACK releases SDA at once
      expect_v("ack_sda_driven", 8'h00);
      expect_v("ack_sda_rst", 8'h01);
      expect_v("ack_busy_rst", 8'h00);
      i2c_start();
      for (int i = 7; i >= 0; i--) bit_w(i == 7 || i == 5);
      m_drv = 1'b0;
      tk(4);
      observe("ack_sda_driven", sda_lvl());
      rst = 1'b0;
      #1;
      observe("ack_sda_rst", sda_lvl());
      observe("ack_busy_rst", {7'd0, busy});
      tk(2);
      rst = 1'b1;
      tk(4);

      // Repeated START mid-byte, then read 0x50 -> RESET0
      expect_v("rs_aack", 8'h00);
      expect_v("rs_data", 8'h00);
      expect_v("rs_busy_end", 8'h00);
      i2c_start();
      bit_w(1'b1);
      bit_w(1'b0);
      bit_w(1'b1);
      i2c_start();
      byte_w(8'hA1, a); observe("rs_aack", {7'd0, a});
      byte_r(1'b1, -1, 8'h00, d); observe("rs_data", d);
      i2c_stop();
      observe("rs_busy_end", {7'd0, busy});

      tk(4);
      done = 1'b1;
   end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- I2C target (slave) that sits downstream of the team's I2C controller on the shared SCL/SDA bus.
- Answers four consecutive 7-bit addresses. The low 2 address bits select one of four 8-bit registers: two read/write, one read-only status, one write-only command.
- Matches the controller's single-byte transactions: address+R/W, then data.
- Oversamples SCL/SDA on the system clock. SDA is open-drain; the bus pull-up is external.

Parameters:
- BASE_ADDR, 5'b10100, upper 5 address bits; the block answers BASE_ADDR,2'b00..2'b11 (0x50-0x53 by default).
- RESET0, 8'h00, reset value of reg0.
- RESET1, 8'h3C, reset value of reg1.

Ports:
- clk  input  1  system clock; SCL high and low phases each >= 4 clk cycles.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- scl  input  1  I2C clock from the controller.
- sda  inout  1  I2C data; the block drives only 0, otherwise Z.
- status_in  input  8  value returned by a read of reg2 (RO).
- reg0_out  output  8  reg0 (RW) contents.
- reg1_out  output  8  reg1 (RW) contents.
- cmd_data  output  8  last byte written to reg3 (WO).
- cmd_valid  output  1  one-clk pulse when cmd_data is updated.
- busy  output  1  high from the address match until STOP or reset.

Behaviour:
- Reset (rst=0, async):
  - reg0_out=RESET0, reg1_out=RESET1, cmd_data=0, cmd_valid=0, busy=0.
  - SDA released; state IDLE.
- Input path:
  - scl and sda each pass through a 2-flop synchroniser.
  - Edges are detected on the synchronised values.
  - START: sda 1->0 while scl=1. STOP: sda 0->1 while scl=1.
- SDA timing: data is sampled on the SCL rising edge. The block changes its SDA drive only in the clk cycle after a detected SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- Transitions:
  - START (from any state, i.e. repeated START): go to ADDR, clear the 3-bit bit counter.
  - STOP (from any state): go to IDLE, release SDA, busy=0.
  - ADDR: shift 8 bits MSB first. After the 8th rising edge:
    - bits[7:3]==BASE_ADDR: go to ADDR_ACK, latch sel=bits[2:1] and rw=bit[0], busy=1.
    - otherwise: go to IGNORE, SDA never driven.
  - ADDR_ACK: drive SDA=0 for one SCL bit.
    - On the falling edge ending the ACK bit, rw=0: go to WR_DATA.
    - rw=1: load the shift register (sel0 reg0, sel1 reg1, sel2 status_in snapshot, sel3 8'h00), then go to RD_DATA.
  - WR_DATA: sample 8 bits. On the falling edge after the 8th bit, commit the write, then go to WR_ACK:
    - sel0/sel1: update the register; output changes 1 clk after the edge.
    - sel3: cmd_data=byte and cmd_valid=1 for exactly 1 clk.
    - sel2: write discarded; WR_ACK releases SDA (NACK).
  - WR_ACK:
    - ACK (SDA=0) for sel0/1/3, NACK for sel2.
    - Afterwards go to WR_DATA; further bytes overwrite the same register.
  - RD_DATA:
    - Shift out 8 bits MSB first; bit 0 drives SDA=0, bit 1 releases.
    - The first bit is driven on the falling edge ending ADDR_ACK.
    - After the 8th bit: release SDA, go to RD_ACK.
  - RD_ACK: sample the controller's ACK on the rising edge.
    - 0: reload the same source and go to RD_DATA.
    - 1 (NACK): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Boundaries:
  - SCL edge and START/STOP in the same clk: START/STOP wins.
  - status_in is snapshotted once per read byte; changes mid-byte are not visible.
  - Reset mid-transaction releases SDA in the same cycle; partial writes are discarded.
  - cmd_valid is never asserted for a discarded or incomplete byte.

Test Plan:
- Write 0x50 (W), data 0xA5 -> address ACK and data ACK; reg0_out=0xA5 one clk after the 8th-bit falling edge; reg1_out stays 0x3C.
- After reset, read 0x51 (R) -> controller receives 0x3C; controller NACKs, STOP -> busy 1->0, SDA released.
- status_in=0x5A, read 0x52 -> 0x5A received. Then write 0x52 with 0xFF -> data NACK, no register change, cmd_valid stays 0.
- Write 0x53 with 0x7E -> cmd_data=0x7E, cmd_valid high exactly 1 clk. Then read 0x53 -> 0x00 received.
- Address 0x48 -> SDA never driven, controller sees NACK and issues STOP; busy stays 0, all registers unchanged.
- rst=0 during the 4th address bit of a write to 0x50 -> SDA released immediately, registers at reset values. Repeated START mid-byte then read 0x50 -> RESET0 returned.
